// File: rtl/dsp_mac_seq.sv
// Dot-product sequencer for a DSP48-style MAC slice: issues operand pairs, steers OPMODE/CEP, returns P per packet.
// Optional macro DSP_MAC_SEQ_CARRY_EN adds the sticky RES_CARRY output.

module dsp_mac_seq #(
    parameter int LEN     = 8,
    parameter int OPM_DLY = 2,
    parameter int RES_DLY = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [17:0] IN_A,
    input  logic [17:0] IN_B,
    output logic [17:0] A_OUT,
    output logic [17:0] B_OUT,
    output logic        CEAB_OUT,
    output logic [7:0]  OPMODE_OUT,
    output logic        CEP_OUT,
    input  logic [47:0] P_IN,
    input  logic        CARRYOUT_IN,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [47:0] RES_DATA,
    output logic        BUSY
`ifdef DSP_MAC_SEQ_CARRY_EN
    ,
    output logic        RES_CARRY
`endif
);

    localparam int CNT_W   = $clog2(LEN + 1);
    localparam int DRN_CYC = OPM_DLY + RES_DLY + 1;
    localparam int DRN_W   = $clog2(DRN_CYC + 1);

    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(LEN);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRN_CYC - 1);

    localparam logic [7:0] OPM_LOAD = 8'h01;
    localparam logic [7:0] OPM_ACC  = 8'h09;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [DRN_W-1:0]   r_drn_cnt;
    logic               w_accept;
    logic               w_last;
    logic               w_drn_end;
    logic [OPM_DLY-1:0] r_vld_p;
    logic [OPM_DLY-1:0] r_first_p;

    assign w_accept  = IN_VALID & IN_READY;
    // In IDLE the count is treated as zero, so an accept on the first IDLE cycle is element 0.
    assign w_cnt_inc = ((r_state == S_IDLE) ? '0 : r_cnt) + CNT_W'(1);
    assign w_last    = w_accept && (w_cnt_inc == LEN_C);
    assign w_drn_end = (r_state == S_DRAIN) && (r_drn_cnt == DRN_LAST);

    assign BUSY      = (r_state != S_IDLE);
    assign RES_VALID = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_last ? S_DRAIN : S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drn_end) w_state_nxt = S_DONE;
            S_DONE:  if (RES_READY) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_drn_cnt <= '0;
            IN_READY  <= 1'b0;
            RES_DATA  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            IN_READY <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RUN);
            if (w_accept)
                r_cnt <= w_cnt_inc;
            else if (r_state == S_IDLE)
                r_cnt <= '0;
            r_drn_cnt <= (r_state == S_DRAIN) ? r_drn_cnt + DRN_W'(1) : '0;
            if (w_drn_end)
                RES_DATA <= P_IN;
        end
    end

    // Issue stage, OPM_DLY-deep shift line, then OPMODE/CEP toward the post-adder
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            A_OUT      <= '0;
            B_OUT      <= '0;
            CEAB_OUT   <= 1'b0;
            r_vld_p    <= '0;
            r_first_p  <= '0;
            CEP_OUT    <= 1'b0;
            OPMODE_OUT <= 8'h00;
        end else begin
            CEAB_OUT <= w_accept;
            if (w_accept) begin
                A_OUT <= IN_A;
                B_OUT <= IN_B;
            end
            r_vld_p[0]   <= w_accept;
            r_first_p[0] <= w_accept && (r_state == S_IDLE);
            for (int i = 1; i < OPM_DLY; i++) begin
                r_vld_p[i]   <= r_vld_p[i-1];
                r_first_p[i] <= r_first_p[i-1];
            end
            CEP_OUT    <= r_vld_p[OPM_DLY-1];
            OPMODE_OUT <= (r_vld_p[OPM_DLY-1] && r_first_p[OPM_DLY-1]) ? OPM_LOAD : OPM_ACC;
        end
    end

`ifdef DSP_MAC_SEQ_CARRY_EN
    logic r_carry;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            r_carry <= 1'b0;
        else if (w_accept && (r_state == S_IDLE))
            r_carry <= 1'b0;
        else if (CARRYOUT_IN && (CEP_OUT || (r_state == S_DRAIN)))
            r_carry <= 1'b1;
    end

    assign RES_CARRY = r_carry;
`else
    logic w_unused_carry;
    assign w_unused_carry = CARRYOUT_IN;
`endif

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: LEN=4 instance checked every cycle against a packet-level model, plus a LEN=1 instance.
// Build with DSP_MAC_SEQ_CARRY_EN defined to also exercise RES_CARRY.

module tb_dsp_mac_seq;

    localparam int LEN  = 4;
    localparam int DRN  = 5;

    logic CLK = 1'b0;
    logic RSTN = 1'b1;

    logic        IN_VALID = 1'b0, IN_READY;
    logic [17:0] IN_A = '0, IN_B = '0, A_OUT, B_OUT;
    logic        CEAB_OUT, CEP_OUT, RES_VALID, BUSY;
    logic [7:0]  OPMODE_OUT;
    logic [47:0] P_IN = '0, RES_DATA;
    logic        CARRYOUT_IN = 1'b0, RES_READY = 1'b0;

    logic        IN_VALID1 = 1'b0, IN_READY1;
    logic [17:0] IN_A1 = '0, IN_B1 = '0, A_OUT1, B_OUT1;
    logic        CEAB_OUT1, CEP_OUT1, RES_VALID1, BUSY1;
    logic [7:0]  OPMODE_OUT1;
    logic [47:0] P_IN1 = '0, RES_DATA1;
    logic        RES_READY1 = 1'b0;
`ifdef DSP_MAC_SEQ_CARRY_EN
    logic        RES_CARRY, RES_CARRY1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    dsp_mac_seq #(.LEN(LEN), .OPM_DLY(2), .RES_DLY(2)) u_dut (
        .CLK(CLK), .RSTN(RSTN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
        .A_OUT(A_OUT), .B_OUT(B_OUT), .CEAB_OUT(CEAB_OUT),
        .OPMODE_OUT(OPMODE_OUT), .CEP_OUT(CEP_OUT),
        .P_IN(P_IN), .CARRYOUT_IN(CARRYOUT_IN),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .BUSY(BUSY)
`ifdef DSP_MAC_SEQ_CARRY_EN
        , .RES_CARRY(RES_CARRY)
`endif
    );

    dsp_mac_seq #(.LEN(1), .OPM_DLY(2), .RES_DLY(2)) u_dut1 (
        .CLK(CLK), .RSTN(RSTN),
        .IN_VALID(IN_VALID1), .IN_READY(IN_READY1), .IN_A(IN_A1), .IN_B(IN_B1),
        .A_OUT(A_OUT1), .B_OUT(B_OUT1), .CEAB_OUT(CEAB_OUT1),
        .OPMODE_OUT(OPMODE_OUT1), .CEP_OUT(CEP_OUT1),
        .P_IN(P_IN1), .CARRYOUT_IN(1'b0),
        .RES_VALID(RES_VALID1), .RES_READY(RES_READY1), .RES_DATA(RES_DATA1), .BUSY(BUSY1)
`ifdef DSP_MAC_SEQ_CARRY_EN
        , .RES_CARRY(RES_CARRY1)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // DSP slice model: AREG -> MREG -> P (add with optional feedback) -> one settle stage
    logic [47:0] d_areg = '0, d_mreg = '0, d_p = '0;
    logic [47:0] e_areg = '0, e_mreg = '0, e_p = '0;
    always @(posedge CLK) begin
        if (CEAB_OUT) d_areg <= 48'(A_OUT) * 48'(B_OUT);
        d_mreg <= d_areg;
        if (CEP_OUT) d_p <= ((OPMODE_OUT == 8'h01) ? 48'd0 : d_p) + d_mreg;
        P_IN <= d_p;
        if (CEAB_OUT1) e_areg <= 48'(A_OUT1) * 48'(B_OUT1);
        e_mreg <= e_areg;
        if (CEP_OUT1) e_p <= ((OPMODE_OUT1 == 8'h01) ? 48'd0 : e_p) + e_mreg;
        P_IN1 <= e_p;
    end

    int sr;
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) sr <= 0;
        else if (sr == 0) sr <= 1;
    end

    // Packet-level reference model for the LEN=4 instance
    int          m_cnt = 0, m_drain = 0;
    bit          m_done = 0;
    logic [47:0] m_sum = '0, m_res = '0;
    logic [17:0] m_a = '0, m_b = '0;
    logic [2:0]  h_acc = '0, h_first = '0;
    logic [7:0]  opm_q[$];

    always @(negedge CLK) begin
        bit exp_ready, acc, first;
        if (!RSTN) begin
            chk("rst_in_ready", IN_READY, 0);
            chk("rst_ceab", CEAB_OUT, 0);
            chk("rst_cep", CEP_OUT, 0);
            chk("rst_opmode", OPMODE_OUT, 0);
            chk("rst_ab", {A_OUT, B_OUT}, 0);
            chk("rst_res", {RES_VALID, BUSY, RES_DATA}, 0);
            m_cnt = 0; m_drain = 0; m_done = 0; m_a = '0; m_b = '0;
            h_acc = '0; h_first = '0;
        end else begin
            exp_ready = (sr != 0) && (m_drain == 0) && !m_done;
            chk("in_ready", IN_READY, exp_ready);
            chk("busy", BUSY, (m_cnt != 0) || (m_drain != 0) || m_done);
            chk("ceab", CEAB_OUT, h_acc[0]);
            chk("a_out", A_OUT, m_a);
            chk("b_out", B_OUT, m_b);
            chk("cep", CEP_OUT, h_acc[2]);
            chk("opmode", OPMODE_OUT, (sr == 0) ? 8'h00 : (h_acc[2] && h_first[2]) ? 8'h01 : 8'h09);
            chk("res_valid", RES_VALID, m_done);
            if (m_done) chk("res_data", RES_DATA, m_res);
            if (CEP_OUT) opm_q.push_back(OPMODE_OUT);

            acc   = IN_VALID && exp_ready;
            first = acc && (m_cnt == 0);
            h_acc   = {h_acc[1:0], acc};
            h_first = {h_first[1:0], first};
            if (m_done && RES_READY) m_done = 0;
            if (m_drain != 0) begin
                m_drain--;
                if (m_drain == 0) begin
                    m_done = 1;
                    m_res  = m_sum;
                end
            end
            if (acc) begin
                m_a   = IN_A;
                m_b   = IN_B;
                m_sum = (first ? 48'd0 : m_sum) + 48'(IN_A) * 48'(IN_B);
                m_cnt++;
                if (m_cnt == LEN) begin
                    m_cnt   = 0;
                    m_drain = DRN;
                end
            end
        end
    end

    // All drivers below start and end at posedge + 1
    task automatic send(input logic [17:0] a, input logic [17:0] b, input int gap);
        int t = 0;
        IN_VALID = 1'b1; IN_A = a; IN_B = b;
        @(negedge CLK);
        while (!IN_READY && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (!IN_READY) chk("send_timeout", 0, 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge CLK);
            #1;
        end
    endtask

    task automatic get_res(input int hold, output logic [47:0] d);
        int t = 0;
        RES_READY = 1'b0;
        @(negedge CLK);
        while (!RES_VALID && t < 100) begin
            @(negedge CLK);
            t++;
        end
        d = RES_DATA;
        if (!RES_VALID) begin
            chk("res_timeout", 0, 1);
            d = '0;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            chk("hold_valid", RES_VALID, 1);
            chk("hold_data", RES_DATA, d);
            chk("hold_in_ready", IN_READY, 0);
        end
        @(posedge CLK); #1;
        RES_READY = 1'b1;
        @(posedge CLK); #1;
        RES_READY = 1'b0;
    endtask

    task automatic packet_1to8(input int gap, input int hold, output logic [47:0] d);
        for (int i = 0; i < 4; i++)
            send(18'(2*i + 1), 18'(2*i + 2), gap);
        get_res(hold, d);
    endtask

    initial begin
        logic [47:0] d;
        int t;
        #2 RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RSTN = 1'b1;
        @(posedge CLK); #1;

        // back-to-back packet
        opm_q.delete();
        packet_1to8(0, 0, d);
        chk("b2b_result", d, 48'h64);
        chk("b2b_opm_cnt", opm_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < opm_q.size()) chk("b2b_opm_seq", opm_q[i], (i == 0) ? 8'h01 : 8'h09);

        // three-cycle bubbles between pairs
        opm_q.delete();
        packet_1to8(3, 0, d);
        chk("gap_result", d, 48'h64);
        chk("gap_cep_cnt", opm_q.size(), 4);

        // RES_READY held off in DONE
        packet_1to8(0, 10, d);
        chk("hold_result", d, 48'h64);

        // reset mid-packet, then (1,1)x4
        send(18'd9, 18'd9, 0);
        send(18'd9, 18'd9, 0);
        RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("rst_no_valid", RES_VALID, 0);
        end
        @(posedge CLK); #1;
        for (int i = 0; i < 4; i++) send(18'd1, 18'd1, 0);
        get_res(0, d);
        chk("post_rst_result", d, 48'd4);

`ifdef DSP_MAC_SEQ_CARRY_EN
        for (int i = 0; i < 4; i++) send(18'(2*i + 1), 18'(2*i + 2), 0);
        CARRYOUT_IN = 1'b1;
        @(posedge CLK); #1;
        CARRYOUT_IN = 1'b0;
        get_res(0, d);
        chk("carry_set", RES_CARRY, 1);
        packet_1to8(0, 0, d);
        chk("carry_clear", RES_CARRY, 0);
`endif

        // LEN=1 instance: IDLE straight to DRAIN
        IN_VALID1 = 1'b1; IN_A1 = 18'h3FFFF; IN_B1 = 18'h2;
        t = 0;
        @(negedge CLK);
        while (!IN_READY1 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        chk("len1_ready", IN_READY1, 1);
        @(posedge CLK); #1;
        IN_VALID1 = 1'b0;
        @(negedge CLK);
        chk("len1_busy", BUSY1, 1);
        chk("len1_drain_not_ready", IN_READY1, 0);
        t = 0;
        while (!RES_VALID1 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        chk("len1_valid", RES_VALID1, 1);
        chk("len1_result", RES_DATA1, 48'h7FFFE);
        @(posedge CLK); #1;
        RES_READY1 = 1'b1;
        @(posedge CLK); #1;
        RES_READY1 = 1'b0;
        @(negedge CLK);
        chk("len1_idle_busy", BUSY1, 0);
        chk("len1_idle_ready", IN_READY1, 1);
        chk("len1_idle_valid", RES_VALID1, 0);
        @(posedge CLK); #1;

        // randomized packets, gaps and result back-pressure
        for (int p = 0; p < 25; p++) begin
            for (int e = 0; e < 4; e++)
                send(18'($urandom), 18'($urandom), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0);
            get_res($urandom_range(0, 3), d);
        end

        repeat (3) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
